rca_accuracy_ctrl: RTL and testbench
====================================

Name: rca_accuracy_ctrl

Overview:
- Adaptive accuracy controller that sequences one external 16-bit dynamic-mode approximate ripple-carry adder.
- Accepts operand transactions over valid/ready and drives the adder's A/B/Cin/mode. Registers the approximate {Cout,Sum} as the result.
- Computes the exact sum in parallel, accumulates absolute error over fixed windows, and steps the adder mode along an accuracy ladder to hold error inside a budget.

Parameters:
- WINDOW, 16: accepted ops per evaluation window; power of two, at least 2.
- HI_THRESH, 64: window error sum above this value steps one level toward exact.
- LO_THRESH, 8: window error sum below this value steps one level toward aggressive. Must be no greater than HI_THRESH.
- MAX_LEVEL, 3: highest ladder level allowed, 0..3.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  operand transaction valid
- in_ready  out  1  controller can accept
- in_a  in  16  operand A
- in_b  in  16  operand B
- in_cin  in  1  carry-in
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_sum  out  17  {Cout,Sum} from adder
- out_err  out  17  absolute error of this result
- adder_a  out  16  to adder A
- adder_b  out  16  to adder B
- adder_cin  out  1  to adder Cin
- adder_mode  out  2  to adder mode
- adder_sum  in  16  from adder Sum (combinational)
- adder_cout  in  1  from adder Cout
- cfg_force_en  in  1  override adaptive level
- cfg_force_level  in  2  forced level
- level  out  2  current effective level
- window_done  out  1  one-cycle pulse when a window closes
- last_window_err  out  ACC_W  error sum of last closed window

Behaviour:
- Reset value of every output and state: out_valid=0, out_sum=0, out_err=0, adaptive level=0, window count=0, accumulator=0, window_done=0, last_window_err=0.
- Ladder, from level to adder_mode: 0 maps to 00 (exact), 1 to 10, 2 to 11, 3 to 01.
- Effective level is cfg_force_level when cfg_force_en=1, otherwise the adaptive level. A force value above MAX_LEVEL clamps to MAX_LEVEL.
- adder_a/b/cin pass through in_a/in_b/in_cin combinationally. adder_mode comes from the effective level.
- Handshake: in_ready = !out_valid || out_ready. Accept occurs when in_valid && in_ready.
- Latency is 1 cycle. On accept, out_sum <= {adder_cout,adder_sum}, exact = in_a+in_b+in_cin (17 bits), out_err <= |exact - out_sum value|, and out_valid <= 1.
- out_valid clears when out_ready=1 with no new accept. Outputs hold stable while out_valid && !out_ready.
- Window logic (adaptive only, cfg_force_en=0):
  - Each accept adds the error to ACC_W = 17+log2(WINDOW) bit accumulator, saturating at all-ones, and increments the count.
  - On the WINDOW-th accept, that op's error is included. Then last_window_err <= sum and window_done pulses the next cycle. Count and accumulator clear.
  - Level update on the same edge: sum>HI_THRESH and level>0 gives level-1; sum<LO_THRESH and level<MAX_LEVEL gives level+1; otherwise hold.
  - The new level applies to the next accept.
- While cfg_force_en=1: count and accumulator hold at 0 and the adaptive level is frozen. On deassert, the controller resumes from the frozen level with a fresh window.
- cfg_force_en or cfg_force_level changes take effect combinationally on adder_mode. An op already registered is unaffected.
- Reset mid-transaction: in-flight result is dropped, out_valid=0 immediately, level returns to 0.

Optional Feature:
- RCA_CTRL_STATS_EN defined adds two ports:
  - stat_ops (out, 32): count of accepted ops, wrapping.
  - stat_level_changes (out, 16): count of adaptive level changes, saturating. Forced overrides are not counted.
- Both reset to 0.
- Undefined: these ports and counters are absent, with no other behaviour change.

Decomposition:
- Shared package holds the ladder constants (LEVEL_TO_MODE mapping, MODE_EXACT=2'b00 etc.) and the level/mode typedefs.
- One sub-module, rca_err_window: accumulator, counter, threshold compare, and level register. The top keeps the handshake, the exact adder, and the error subtract.

Test Plan:
- Reset -> level=0, adder_mode=00, out_valid=0, in_ready=1, last_window_err=0.
- WINDOW=4, LO=8, HI=64; 4 accepts A=B=0 Cin=0 at level 0 -> out_err=0 each, window_done pulse, last_window_err=0, level=1, adder_mode=10.
- Force level 3 (mode 01), release, then adaptive at level 3; 4 accepts A=B=0x0010 Cin=0 -> each out_sum=0, out_err=32, last_window_err=128, level=2, adder_mode=11.
- Backpressure: out_ready=0 with out_valid=1 -> in_ready=0; in_valid held 3 cycles gives no accept; out_sum stable and window count unchanged.
- Force: cfg_force_en=1, level=0 mid-window -> adder_mode=00 same cycle; accepts do not close a window; release -> prior adaptive level restored and count=0.
- Reset asserted with out_valid=1 and level=2 -> out_valid=0 and level=0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/rca_accuracy_ctrl_pkg.sv
// Ladder definitions shared by the accuracy controller: level/mode types and the
// level-to-adder-mode map (level 0 is exact, higher levels are more aggressive).
package rca_accuracy_ctrl_pkg;

    localparam int SUM_W = 17;

    typedef logic [1:0] level_t;

    typedef enum logic [1:0] {
        MODE_EXACT = 2'b00,
        MODE_LIGHT = 2'b10,
        MODE_MED   = 2'b11,
        MODE_AGGR  = 2'b01
    } mode_e;

    localparam mode_e LEVEL_TO_MODE [4] = '{MODE_EXACT, MODE_LIGHT, MODE_MED, MODE_AGGR};

    function automatic mode_e level_to_mode(input level_t lvl);
        return LEVEL_TO_MODE[lvl];
    endfunction

endpackage

// File: rtl/rca_accuracy_ctrl_if.sv
// Operand/result stream of the accuracy controller. The master side issues
// operands and consumes results; the controller is the slave.
interface rca_accuracy_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_cin;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] out_sum;
    logic [16:0] out_err;

    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_err
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_err
    );
endinterface

// File: rtl/rca_err_window.sv
// Windowed error accumulator and adaptive ladder level for rca_accuracy_ctrl.
// RCA_CTRL_STATS_EN adds a saturating count of adaptive level changes.
module rca_err_window
    import rca_accuracy_ctrl_pkg::*;
#(
    parameter  int WINDOW    = 16,
    parameter  int HI_THRESH = 64,
    parameter  int LO_THRESH = 8,
    parameter  int MAX_LEVEL = 3,
    localparam int ACC_W     = SUM_W + $clog2(WINDOW)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             acc_en,
    input  logic             force_en,
    input  logic [SUM_W-1:0] err,
    output level_t           level,
    output logic             window_done,
    output logic [ACC_W-1:0] last_window_err
`ifdef RCA_CTRL_STATS_EN
    ,
    output logic [15:0]      stat_level_changes
`endif
);

    localparam int               CNT_W    = $clog2(WINDOW);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);
    localparam logic [ACC_W-1:0] HI_T     = ACC_W'(HI_THRESH);
    localparam logic [ACC_W-1:0] LO_T     = ACC_W'(LO_THRESH);
    localparam level_t           MAX_L    = level_t'(MAX_LEVEL);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
    logic [ACC_W-1:0] last_q, last_d;
    level_t           level_q, level_d;
    logic             done_q, done_d;

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [SUM_W-1:0] b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {{(ACC_W + 1 - SUM_W){1'b0}}, b};
        return s[ACC_W] ? '1 : s[ACC_W-1:0];
    endfunction

    always_comb begin
        acc_sum = sat_add(acc_q, err);
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        last_d  = last_q;
        level_d = level_q;
        done_d  = 1'b0;
        // Forcing parks the window empty and freezes the adaptive level.
        if (force_en) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (acc_en) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d  = '0;
                acc_d  = '0;
                last_d = acc_sum;
                done_d = 1'b1;
                if (acc_sum > HI_T && level_q != 2'd0) begin
                    level_d = level_q - 2'd1;
                end else if (acc_sum < LO_T && level_q < MAX_L) begin
                    level_d = level_q + 2'd1;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                acc_d = acc_sum;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            last_q  <= '0;
            level_q <= '0;
            done_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            last_q  <= last_d;
            level_q <= level_d;
            done_q  <= done_d;
        end
    end

    assign level           = level_q;
    assign window_done     = done_q;
    assign last_window_err = last_q;

`ifdef RCA_CTRL_STATS_EN
    logic [15:0] chg_cnt_q, chg_cnt_d;

    always_comb begin
        chg_cnt_d = chg_cnt_q;
        if (level_d != level_q && chg_cnt_q != 16'hFFFF) begin
            chg_cnt_d = chg_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chg_cnt_q <= '0;
        end else begin
            chg_cnt_q <= chg_cnt_d;
        end
    end

    assign stat_level_changes = chg_cnt_q;
`endif

endmodule

// File: rtl/rca_accuracy_ctrl.sv
// Adaptive accuracy controller for a 16-bit dynamic-mode approximate ripple-carry adder.
// Define RCA_CTRL_STATS_EN to add the stat_ops / stat_level_changes counters.
module rca_accuracy_ctrl
    import rca_accuracy_ctrl_pkg::*;
#(
    parameter  int WINDOW    = 16,
    parameter  int HI_THRESH = 64,
    parameter  int LO_THRESH = 8,
    parameter  int MAX_LEVEL = 3,
    localparam int ACC_W     = SUM_W + $clog2(WINDOW)
) (
    input  logic             clk,
    input  logic             rst,
    rca_accuracy_ctrl_if.slave bus,
    output logic [15:0]      adder_a,
    output logic [15:0]      adder_b,
    output logic             adder_cin,
    output logic [1:0]       adder_mode,
    input  logic [15:0]      adder_sum,
    input  logic             adder_cout,
    input  logic             cfg_force_en,
    input  level_t           cfg_force_level,
    output level_t           level,
    output logic             window_done,
    output logic [ACC_W-1:0] last_window_err
`ifdef RCA_CTRL_STATS_EN
    ,
    output logic [31:0]      stat_ops,
    output logic [15:0]      stat_level_changes
`endif
);

    localparam level_t MAX_L = level_t'(MAX_LEVEL);

    level_t           adapt_level;
    level_t           force_level;
    logic             accept;
    logic [SUM_W-1:0] approx_sum;
    logic [SUM_W-1:0] exact_sum;
    logic [SUM_W-1:0] err;

    logic             out_valid_q, out_valid_d;
    logic [SUM_W-1:0] out_sum_q, out_sum_d;
    logic [SUM_W-1:0] out_err_q, out_err_d;

    function automatic logic [SUM_W-1:0] abs_diff(input logic [SUM_W-1:0] x,
                                                  input logic [SUM_W-1:0] y);
        logic signed [SUM_W:0] d;
        d = $signed({1'b0, x}) - $signed({1'b0, y});
        return d[SUM_W] ? SUM_W'(-d) : SUM_W'(d);
    endfunction

    // A forced level beyond the ladder ceiling is clamped, never rejected.
    assign force_level = (int'(cfg_force_level) > MAX_LEVEL) ? MAX_L : cfg_force_level;
    assign level       = cfg_force_en ? force_level : adapt_level;
    assign adder_mode  = level_to_mode(level);
    assign adder_a     = bus.in_a;
    assign adder_b     = bus.in_b;
    assign adder_cin   = bus.in_cin;

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    assign approx_sum = {adder_cout, adder_sum};
    assign exact_sum  = {1'b0, bus.in_a} + {1'b0, bus.in_b} + {16'd0, bus.in_cin};
    assign err        = abs_diff(exact_sum, approx_sum);

    always_comb begin
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_err_d   = out_err_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_sum_d   = approx_sum;
            out_err_d   = err;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_err_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_err_q   <= out_err_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_err   = out_err_q;

    rca_err_window #(
        .WINDOW    (WINDOW),
        .HI_THRESH (HI_THRESH),
        .LO_THRESH (LO_THRESH),
        .MAX_LEVEL (MAX_LEVEL)
    ) u_err_window (
        .clk             (clk),
        .rst             (rst),
        .acc_en          (accept),
        .force_en        (cfg_force_en),
        .err             (err),
        .level           (adapt_level),
        .window_done     (window_done),
        .last_window_err (last_window_err)
`ifdef RCA_CTRL_STATS_EN
        ,
        .stat_level_changes (stat_level_changes)
`endif
    );

`ifdef RCA_CTRL_STATS_EN
    logic [31:0] ops_q, ops_d;

    assign ops_d = accept ? ops_q + 32'd1 : ops_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ops_q <= '0;
        end else begin
            ops_q <= ops_d;
        end
    end

    assign stat_ops = ops_q;
`endif

endmodule

// File: tb/tb_rca_accuracy_ctrl.sv
// Scoreboard bench for rca_accuracy_ctrl: randomized operands against a window/ladder model.
module tb_rca_accuracy_ctrl;

    localparam int WINDOW = 4;
    localparam int HI     = 64;
    localparam int LO     = 8;
    localparam int MAXL   = 3;
    localparam int ACC_W  = 17 + $clog2(WINDOW);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rca_accuracy_ctrl_if bus();

    logic [15:0]      adder_a, adder_b, adder_sum;
    logic             adder_cin, adder_cout;
    logic [1:0]       adder_mode, level, cfg_force_level;
    logic             cfg_force_en, window_done;
    logic [ACC_W-1:0] last_window_err;
`ifdef RCA_CTRL_STATS_EN
    logic [31:0]      stat_ops;
    logic [15:0]      stat_level_changes;
`endif

    rca_accuracy_ctrl #(
        .WINDOW(WINDOW), .HI_THRESH(HI), .LO_THRESH(LO), .MAX_LEVEL(MAXL)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
        .adder_mode(adder_mode), .adder_sum(adder_sum), .adder_cout(adder_cout),
        .cfg_force_en(cfg_force_en), .cfg_force_level(cfg_force_level),
        .level(level), .window_done(window_done), .last_window_err(last_window_err)
`ifdef RCA_CTRL_STATS_EN
        , .stat_ops(stat_ops), .stat_level_changes(stat_level_changes)
`endif
    );

    // Environment adder: modes 10/11/01 drop the low 2/4/8 bits (zeroed, no carry out of them).
    function automatic logic [16:0] approx_add(input logic [15:0] a, input logic [15:0] b,
                                               input logic c, input logic [1:0] mode);
        int k;
        int unsigned r;
        case (mode)
            2'b10:   k = 2;
            2'b11:   k = 4;
            2'b01:   k = 8;
            default: k = 0;
        endcase
        if (k == 0) r = int'(a) + int'(b) + int'(c);
        else        r = ((int'(a) >> k) + (int'(b) >> k)) << k;
        return r[16:0];
    endfunction

    always_comb {adder_cout, adder_sum} = approx_add(adder_a, adder_b, adder_cin, adder_mode);

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    typedef struct { logic [16:0] sum; logic [16:0] err; } exp_t;
    exp_t sbq[$];
    int   m_win[$];
    int   m_level, m_last, m_ops;
    bit   m_ovalid, m_wdone;
    bit   chk_en;

    function automatic logic [1:0] mode_of(input int lvl);
        case (lvl)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    function automatic int eff_level();
        if (cfg_force_en) return (int'(cfg_force_level) > MAXL) ? MAXL : int'(cfg_force_level);
        return m_level;
    endfunction

    task automatic model_reset();
        sbq.delete();
        m_win.delete();
        m_level = 0; m_last = 0; m_ops = 0;
        m_ovalid = 0; m_wdone = 0;
    endtask

    // One clock of stimulus; inputs are applied 2 time units after the active edge.
    task automatic cycle(input bit v, input logic [15:0] a, input logic [15:0] b,
                         input bit c, input bit ordy);
        bit          acc;
        logic [16:0] ap;
        int          ex, e, s;
        bus.in_valid = v; bus.in_a = a; bus.in_b = b; bus.in_cin = c; bus.out_ready = ordy;
        acc = v && (!m_ovalid || ordy);
        ap  = approx_add(a, b, c, mode_of(eff_level()));
        ex  = int'(a) + int'(b) + int'(c);
        e   = ex - int'(ap);
        if (e < 0) e = -e;
        @(posedge clk);
        m_wdone = 0;
        if (acc) begin
            sbq.push_back('{ap, 17'(e)});
            m_ovalid = 1;
            m_ops++;
        end else if (ordy) begin
            m_ovalid = 0;
        end
        if (cfg_force_en) begin
            m_win.delete();
        end else if (acc) begin
            m_win.push_back(e);
            if (m_win.size() == WINDOW) begin
                s = 0;
                foreach (m_win[i]) s += m_win[i];
                m_last  = s;
                m_wdone = 1;
                if (s > HI && m_level > 0)         m_level--;
                else if (s < LO && m_level < MAXL) m_level++;
                m_win.delete();
            end
        end
        #2;
    endtask

    task automatic do_reset();
        chk_en = 0;
        rst = 1;
        bus.in_valid = 0; bus.out_ready = 1;
        model_reset();
        @(posedge clk);
        #2;
        rst = 0;
        chk_en = 1;
    endtask

    // Monitor: compares presented results with the scoreboard and the visible state with the model.
    logic [16:0] prev_sum, prev_err;
    bit          stall_prev = 0;
    always @(negedge clk) begin
        exp_t x;
        if (chk_en) begin
            check("in_ready", bus.in_ready, !m_ovalid || bus.out_ready);
            check("out_valid", bus.out_valid, m_ovalid);
            check("level", level, eff_level());
            check("adder_mode", adder_mode, mode_of(eff_level()));
            check("window_done", window_done, m_wdone);
            check("last_window_err", last_window_err, m_last);
            if (stall_prev && bus.out_valid) begin
                check("hold_sum", bus.out_sum, prev_sum);
                check("hold_err", bus.out_err, prev_err);
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            prev_sum = bus.out_sum;
            prev_err = bus.out_err;
            if (bus.out_valid && bus.out_ready) begin
                if (sbq.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    x = sbq.pop_front();
                    check("out_sum", bus.out_sum, x.sum);
                    check("out_err", bus.out_err, x.err);
                end
            end
        end else begin
            stall_prev = 0;
        end
    end

    initial begin
        int saved;
        logic [15:0] ra, rb;
        rst = 1; chk_en = 0;
        bus.in_valid = 0; bus.in_a = 0; bus.in_b = 0; bus.in_cin = 0; bus.out_ready = 0;
        cfg_force_en = 0; cfg_force_level = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        rst = 0;
        #1;
        check("rst_level", level, 0);
        check("rst_mode", adder_mode, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_last_err", last_window_err, 0);
        check("rst_out_sum", bus.out_sum, 0);
        chk_en = 1;

        // Zero-error window steps toward aggressive
        repeat (WINDOW) cycle(1, 16'h0, 16'h0, 0, 1);
        check("w0_done", window_done, 1);
        check("w0_level", level, 1);
        check("w0_mode", adder_mode, 2'b10);
        check("w0_last", last_window_err, 0);
        repeat (2 * WINDOW) cycle(1, 16'h0, 16'h0, 0, 1);
        check("w2_level", level, 3);

        // Force/release at level 3, then a high-error window steps back
        cfg_force_en = 1; cfg_force_level = 3;
        cycle(0, 0, 0, 0, 1);
        cfg_force_en = 0;
        cycle(0, 0, 0, 0, 1);
        repeat (WINDOW) cycle(1, 16'h0010, 16'h0010, 0, 1);
        check("hi_last", last_window_err, 128);
        check("hi_level", level, 2);
        check("hi_mode", adder_mode, 2'b11);

        // Backpressure: one accepted result stalls, further valid ops are refused
        cycle(1, 16'h1234, 16'h0F0F, 1, 0);
        repeat (3) cycle(1, 16'h5555, 16'h1111, 0, 0);
        check("bp_in_ready", bus.in_ready, 0);
        cycle(0, 0, 0, 0, 1);

        // Force mid-window
        repeat (2) cycle(1, 16'(($urandom_range(0, 15))), 16'(($urandom_range(0, 15))), 0, 1);
        saved = m_level;
        cfg_force_en = 1; cfg_force_level = 0;
        #1;
        check("force_mode", adder_mode, 2'b00);
        repeat (2 * WINDOW) cycle(1, 16'($urandom), 16'($urandom), 1'($urandom), 1);
        cfg_force_en = 0;
        #1;
        check("release_level", level, saved);
        cycle(0, 0, 0, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                cfg_force_en = 1'($urandom);
                cfg_force_level = 2'($urandom);
            end
            if ($urandom_range(0, 1) == 0) begin
                ra = 16'($urandom_range(0, 15)); rb = 16'($urandom_range(0, 15));
            end else begin
                ra = 16'($urandom); rb = 16'($urandom);
            end
            cycle(1'($urandom_range(0, 3) != 0), ra, rb, 1'($urandom),
                  $urandom_range(0, 3) != 0);
        end
        cfg_force_en = 0;
        cycle(0, 0, 0, 0, 1);

        // Asynchronous reset with a stalled result at level 2
        do_reset();
        repeat (2 * WINDOW) cycle(1, 16'h0, 16'h0, 0, 1);
        cycle(1, 16'hABCD, 16'h1357, 0, 0);
        check("pre_rst_valid", bus.out_valid, 1);
        check("pre_rst_level", level, 2);
        chk_en = 0;
        rst = 1;
        #1;
        check("async_rst_valid", bus.out_valid, 0);
        check("async_rst_level", level, 0);
        check("async_rst_mode", adder_mode, 0);
        model_reset();
        @(posedge clk);
        #2;
        rst = 0;
        chk_en = 1;
        repeat (WINDOW) cycle(1, 16'h0003, 16'h0004, 1, 1);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        check("sb_drained", sbq.size(), 0);
`ifdef RCA_CTRL_STATS_EN
        check("stat_ops", stat_ops, m_ops);
`endif
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
